// File: rtl/collision_scheduler_pkg.sv
// Shared game geometry constants and the scheduler state encoding.
package collision_scheduler_pkg;

  localparam int CAR_WIDTH  = 16;
  localparam int CAR_HEIGHT = 32;
  localparam int X_W        = 8;
  localparam int Y_W        = 10;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_REQ   = 2'd1,
    ST_CHECK = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

endpackage

// File: rtl/collision_scheduler_box_overlap.sv
// Inclusive-edge bounding-box overlap test. Right/bottom edges are formed one
// bit wider than the coordinates so boxes near the screen limit never wrap.
module box_overlap
  import collision_scheduler_pkg::*;
#(
  parameter int BOX_W = CAR_WIDTH,
  parameter int BOX_H = CAR_HEIGHT
) (
  input  logic [X_W-1:0] px_i,
  input  logic [Y_W-1:0] py_i,
  input  logic [X_W-1:0] ox_i,
  input  logic [Y_W-1:0] oy_i,
  output logic           overlap_o
);

  logic [X_W:0] px_end, ox_end;
  logic [Y_W:0] py_end, oy_end;

  assign px_end = {1'b0, px_i} + (X_W+1)'(BOX_W);
  assign ox_end = {1'b0, ox_i} + (X_W+1)'(BOX_W);
  assign py_end = {1'b0, py_i} + (Y_W+1)'(BOX_H);
  assign oy_end = {1'b0, oy_i} + (Y_W+1)'(BOX_H);

  assign overlap_o = ({1'b0, px_i} <= ox_end) && ({1'b0, ox_i} <= px_end) &&
                     ({1'b0, py_i} <= oy_end) && ({1'b0, oy_i} <= py_end);

endmodule

// File: rtl/collision_scheduler.sv
// Per-frame collision scan: one shared overlap checker walks every obstacle
// slot through the table read port and publishes a hit mask at the end.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_IDLE  | waiting for frame_tick; results hold from the last scan
// ST_REQ   | obs_req high for slot_q, waiting for obs_valid
// ST_CHECK | overlap test on the registered operands of slot_q
// ST_DONE  | results published this cycle (done high), back to idle
module collision_scheduler
  import collision_scheduler_pkg::*;
#(
  parameter int N_OBSTACLES = 8,
  parameter int IDX_W       = $clog2(N_OBSTACLES)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   frame_tick,
  input  logic [X_W-1:0]         player_x,
  input  logic [Y_W-1:0]         player_y,
  output logic                   obs_req,
  output logic [IDX_W-1:0]       obs_idx,
  input  logic                   obs_valid,
  input  logic [X_W-1:0]         obs_x,
  input  logic [Y_W-1:0]         obs_y,
  input  logic                   obs_active,
  output logic                   busy,
  output logic                   done,
  output logic                   hit,
  output logic [N_OBSTACLES-1:0] hit_mask,
  output logic [IDX_W-1:0]       first_hit_idx,
  output logic                   overrun
);

  state_e                 state_q;
  logic [IDX_W-1:0]       slot_q;
  logic [X_W-1:0]         px_q, ox_q;
  logic [Y_W-1:0]         py_q, oy_q;
  logic                   act_q;
  logic [N_OBSTACLES-1:0] work_q, work_d, hit_mask_q;
  logic [IDX_W-1:0]       first_q, first_d;
  logic                   hit_q, done_q, busy_q, req_q, overrun_q;
  logic                   overlap;

  box_overlap #(
    .BOX_W (CAR_WIDTH),
    .BOX_H (CAR_HEIGHT)
  ) u_box_overlap (
    .px_i      (px_q),
    .py_i      (py_q),
    .ox_i      (ox_q),
    .oy_i      (oy_q),
    .overlap_o (overlap)
  );

  // Working mask including the slot under test, and its lowest set index.
  always_comb begin
    work_d         = work_q;
    work_d[slot_q] = act_q & overlap;
    first_d        = '0;
    for (int i = N_OBSTACLES - 1; i >= 0; i--) begin
      if (work_d[i]) first_d = IDX_W'(i);
    end
  end

  // Scan FSM with all outputs registered. Results are loaded on the last
  // CHECK so they appear in the same cycle as the done pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      slot_q     <= '0;
      px_q       <= '0;
      py_q       <= '0;
      ox_q       <= '0;
      oy_q       <= '0;
      act_q      <= 1'b0;
      work_q     <= '0;
      hit_mask_q <= '0;
      first_q    <= '0;
      hit_q      <= 1'b0;
      done_q     <= 1'b0;
      busy_q     <= 1'b0;
      req_q      <= 1'b0;
      overrun_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (frame_tick && (state_q != ST_IDLE)) overrun_q <= 1'b1;
      case (state_q)
        ST_IDLE: begin
          if (frame_tick) begin
            px_q    <= player_x;
            py_q    <= player_y;
            slot_q  <= '0;
            work_q  <= '0;
            req_q   <= 1'b1;
            busy_q  <= 1'b1;
            state_q <= ST_REQ;
          end
        end
        ST_REQ: begin
          if (obs_valid) begin
            ox_q    <= obs_x;
            oy_q    <= obs_y;
            act_q   <= obs_active;
            req_q   <= 1'b0;
            state_q <= ST_CHECK;
          end
        end
        ST_CHECK: begin
          work_q <= work_d;
          if (slot_q == IDX_W'(N_OBSTACLES - 1)) begin
            hit_mask_q <= work_d;
            hit_q      <= |work_d;
            first_q    <= first_d;
            done_q     <= 1'b1;
            state_q    <= ST_DONE;
          end else begin
            slot_q  <= slot_q + 1'b1;
            req_q   <= 1'b1;
            state_q <= ST_REQ;
          end
        end
        ST_DONE: begin
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign obs_req       = req_q;
  assign obs_idx       = slot_q;
  assign busy          = busy_q;
  assign done          = done_q;
  assign hit           = hit_q;
  assign hit_mask      = hit_mask_q;
  assign first_hit_idx = first_q;
  assign overrun       = overrun_q;

endmodule

// File: tb/tb_collision_scheduler.sv
// Directed bench for collision_scheduler: a table of per-frame scenarios with
// hand-computed results, plus overrun, done-cycle tick and mid-scan reset.
module tb_collision_scheduler;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       frame_tick = 1'b0;
  logic [7:0] player_x = '0;
  logic [9:0] player_y = '0;
  logic       obs_req;
  logic [2:0] obs_idx;
  logic       obs_valid = 1'b0;
  logic [7:0] obs_x = '0;
  logic [9:0] obs_y = '0;
  logic       obs_active = 1'b0;
  logic       busy, done, hit, overrun;
  logic [7:0] hit_mask;
  logic [2:0] first_hit_idx;

  collision_scheduler #(.N_OBSTACLES(8)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .frame_tick    (frame_tick),
    .player_x      (player_x),
    .player_y      (player_y),
    .obs_req       (obs_req),
    .obs_idx       (obs_idx),
    .obs_valid     (obs_valid),
    .obs_x         (obs_x),
    .obs_y         (obs_y),
    .obs_active    (obs_active),
    .busy          (busy),
    .done          (done),
    .hit           (hit),
    .hit_mask      (hit_mask),
    .first_hit_idx (first_hit_idx),
    .overrun       (overrun)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0]       px;
    logic [9:0]       py;
    logic [7:0][7:0]  ox;
    logic [7:0][9:0]  oy;
    logic [7:0]       act;
    int               lat;
    logic [7:0]       mask;
    logic [2:0]       first;
    int               done_cyc;
  } vec_t;

  vec_t vecs[6];

  int   n_checks = 0;
  int   n_err    = 0;
  logic [7:0] prev_mask  = '0;
  logic [2:0] prev_first = '0;
  logic       exp_ovr    = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic init_vec(input int v, input logic [7:0] px, input logic [9:0] py, input int lat,
                          input logic [7:0] mask, input logic [2:0] first);
    vecs[v].px       = px;
    vecs[v].py       = py;
    vecs[v].ox       = '0;
    vecs[v].oy       = '0;
    vecs[v].act      = '0;
    vecs[v].lat      = lat;
    vecs[v].mask     = mask;
    vecs[v].first    = first;
    vecs[v].done_cyc = 8 * (lat + 1) + 1;
  endtask

  task automatic set_slot(input int v, input int s, input logic [7:0] x, input logic [9:0] y,
                          input logic a);
    vecs[v].ox[s]  = x;
    vecs[v].oy[s]  = y;
    vecs[v].act[s] = a;
  endtask

  // Runs one frame of vector v. tick_at: cycle of an extra frame_tick (-1 none).
  // rst_slot: assert reset when REQ for that slot is seen (-1 none).
  task automatic run_scan(input int v, input int tick_at, input int rst_slot);
    int         cyc, req_cnt, exp_slot;
    logic [2:0] held_idx;
    bit         fin;
    cyc = 1; req_cnt = 0; exp_slot = 0; held_idx = '0; fin = 0;
    player_x   = vecs[v].px;
    player_y   = vecs[v].py;
    frame_tick = 1'b1;
    @(posedge clk); #1;
    while (!fin) begin
      frame_tick = (cyc == tick_at);
      if (tick_at >= 1 && cyc == tick_at) exp_ovr = 1'b1;
      if (rst_slot >= 0 && obs_req && obs_idx == 3'(rst_slot)) begin
        rst_n = 1'b0;
        obs_valid = 1'b0;
        frame_tick = 1'b0;
        #1;
        chk("rst_obs_req", obs_req, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_hit", hit, 0);
        chk("rst_mask", hit_mask, 0);
        chk("rst_first", first_hit_idx, 0);
        chk("rst_overrun", overrun, 0);
        exp_ovr = 1'b0; prev_mask = '0; prev_first = '0;
        repeat (3) begin
          @(posedge clk); #1;
          chk("rst_no_done", done, 0);
        end
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("post_rst_idle", busy, 0);
        return;
      end
      if (obs_req) begin
        req_cnt++;
        if (req_cnt == 1) begin
          chk("obs_idx_order", obs_idx, exp_slot);
          held_idx = obs_idx;
        end else begin
          chk("obs_idx_stall", obs_idx, held_idx);
        end
        obs_valid  = (req_cnt >= vecs[v].lat);
        obs_x      = vecs[v].ox[obs_idx];
        obs_y      = vecs[v].oy[obs_idx];
        obs_active = vecs[v].act[obs_idx];
        if (obs_valid) exp_slot++;
      end else begin
        req_cnt   = 0;
        obs_valid = 1'b0;
      end
      chk("busy_in_scan", busy, 1);
      if (done) begin
        chk("done_cycle", cyc, vecs[v].done_cyc);
        chk("hit_mask", hit_mask, vecs[v].mask);
        chk("hit", hit, |vecs[v].mask);
        chk("first_hit_idx", first_hit_idx, vecs[v].first);
        chk("slots_read", exp_slot, 8);
        fin = 1;
      end else begin
        chk("mask_stable", hit_mask, prev_mask);
        chk("first_stable", first_hit_idx, prev_first);
        if (cyc > 200) begin
          chk("done_timeout", cyc, vecs[v].done_cyc);
          fin = 1;
        end
      end
      @(posedge clk); #1;
      cyc++;
    end
    frame_tick = 1'b0;
    obs_valid  = 1'b0;
    chk("done_one_cycle", done, 0);
    chk("idle_after_done", busy, 0);
    chk("no_req_after_done", obs_req, 0);
    chk("overrun", overrun, exp_ovr);
    chk("results_hold", hit_mask, vecs[v].mask);
    prev_mask  = vecs[v].mask;
    prev_first = vecs[v].first;
    @(posedge clk); #1;
  endtask

  initial begin
    init_vec(0, 8'd100, 10'd200, 1, 8'h08, 3'd3);
    set_slot(0, 3, 8'd110, 10'd220, 1'b1);
    init_vec(1, 8'd100, 10'd200, 1, 8'h01, 3'd0);
    set_slot(1, 0, 8'd116, 10'd232, 1'b1);
    set_slot(1, 1, 8'd117, 10'd200, 1'b1);
    init_vec(2, 8'd0, 10'd0, 1, 8'h00, 3'd0);
    set_slot(2, 2, 8'd250, 10'd1010, 1'b1);
    init_vec(3, 8'd100, 10'd200, 2, 8'h00, 3'd0);
    set_slot(3, 4, 8'd100, 10'd200, 1'b0);
    init_vec(4, 8'd100, 10'd200, 3, 8'h24, 3'd2);
    set_slot(4, 5, 8'd90, 10'd190, 1'b1);
    set_slot(4, 2, 8'd84, 10'd168, 1'b1);
    init_vec(5, 8'd50, 10'd500, 2, 8'h42, 3'd1);
    set_slot(5, 1, 8'd60, 10'd520, 1'b1);
    set_slot(5, 6, 8'd40, 10'd480, 1'b1);

    #12;
    chk("reset_obs_req", obs_req, 0);
    chk("reset_obs_idx", obs_idx, 0);
    chk("reset_busy", busy, 0);
    chk("reset_done", done, 0);
    chk("reset_hit", hit, 0);
    chk("reset_mask", hit_mask, 0);
    chk("reset_first", first_hit_idx, 0);
    chk("reset_overrun", overrun, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;

    for (int v = 0; v < 5; v++) run_scan(v, -1, -1);
    run_scan(5, 5, -1);
    run_scan(0, -1, 4);
    run_scan(0, 17, -1);
    chk("tick_in_done_not_started", busy, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule

// File: doc/collision_scheduler.md
# collision_scheduler

Time-multiplexes one bounding-box overlap checker across all obstacle slots once per video frame. On each frame tick it latches the player car position and walks obstacle slots 0..N_OBSTACLES-1 through a request/valid read port on the obstacle table. It tests each active obstacle against the player and publishes a per-frame hit mask, a hit flag and the lowest hit index to the game-state logic.

## Interface
- N_OBSTACLES, 8: number of obstacle slots scanned per frame; must be at least 2.
- CAR_WIDTH, 16: car and obstacle box width in pixels.
- CAR_HEIGHT, 32: car and obstacle box height in pixels.
- IDX_W, $clog2(N_OBSTACLES): slot index width.
- clk  in  1  system clock; single clock domain.
- rst_n  in  1  asynchronous, active-low reset.
- frame_tick  in  1  one-cycle start pulse, once per frame.
- player_x  in  8  player left edge; sampled only on an accepted frame_tick.
- player_y  in  10  player top edge; sampled only on an accepted frame_tick.
- obs_req  out  1  read request to the obstacle table.
- obs_idx  out  IDX_W  slot being read; stable while obs_req is high.
- obs_valid  in  1  read data valid.
- obs_x  in  8  obstacle left edge.
- obs_y  in  10  obstacle top edge.
- obs_active  in  1  slot occupied.
- busy  out  1  a scan is in progress.
- done  out  1  one-cycle pulse when results update.
- hit  out  1  at least one slot collided in the last completed scan.
- hit_mask  out  N_OBSTACLES  bit i set means slot i collided.
- first_hit_idx  out  IDX_W  lowest colliding slot; 0 when hit=0.
- overrun  out  1  sticky flag: a frame_tick arrived while busy. Cleared only by reset.

## Operation
- FSM states: IDLE, REQ, CHECK, DONE.
- IDLE
  - On frame_tick: latch player_x/player_y, set slot=0, clear the working mask, go to REQ.
- REQ
  - Hold obs_req=1 with obs_idx=slot until obs_valid=1.
  - On the valid cycle: register obs_x, obs_y and obs_active, drop obs_req, go to CHECK.
  - obs_valid while obs_req=0 is ignored.
- CHECK
  - Overlap test on the registered operands. Set working mask bit[slot] = obs_active AND overlap.
  - If slot = N_OBSTACLES-1, go to DONE. Otherwise increment slot and go to REQ.
- DONE
  - Copy the working mask to hit_mask. hit = OR of mask. first_hit_idx = priority encode of mask, lowest index first.
  - Pulse done, return to IDLE.
- Overlap rule: inclusive edges, so touching boxes collide.
  - px <= ox+CAR_WIDTH AND ox <= px+CAR_WIDTH AND py <= oy+CAR_HEIGHT AND oy <= py+CAR_HEIGHT.
  - Sums are computed one bit wider than the operand (9 bits for x, 11 bits for y), so they never wrap.
- frame_tick outside IDLE: ignored, sets overrun; the current scan continues unaffected.
- frame_tick in the same cycle as DONE: ignored, sets overrun.
- Results (hit, hit_mask, first_hit_idx) stay stable between done pulses and do not change mid-scan.
- Reset mid-scan: the FSM returns to IDLE immediately, obs_req drops and results clear; no done pulse is generated.

## Timing
- Reset values: obs_req=0, obs_idx=0, busy=0, done=0, hit=0, hit_mask=0, first_hit_idx=0, overrun=0.
- busy is high from the cycle after an accepted frame_tick through the DONE cycle inclusive.
- Read latency L (cycles from obs_req rising to obs_valid) must be at least 1.
- Per slot: L cycles in REQ plus 1 cycle in CHECK.
- Accepted frame_tick at cycle 0 gives done at cycle N_OBSTACLES*(L+1)+1; results are visible from the same cycle as done.
- With N=8 and L=1, done is at cycle 17.
- All outputs are registered; no combinational path from inputs to outputs.

## Structure
- Shared package/header holds CAR_WIDTH, CAR_HEIGHT, the state encoding and the screen coordinate widths (8-bit x, 10-bit y). Other game blocks use the same constants.
- Sub-module box_overlap: purely combinational, applies the inclusive rule with widened arithmetic. It is instantiated once and reused later by pickup/bonus detection.

## Test plan
- Single hit: N=8, L=1, player (100,200), slot 3 active at (110,220), all others inactive.
  - Expect done at cycle 17, hit=1, hit_mask=8'h08, first_hit_idx=3.
- Edge and wrap: player (100,200).
  - Slot 0 at (116,232) touches both edges: expect a hit.
  - Slot 1 at (117,200): expect no hit.
  - Slot 2 at (250,1010) with player (0,0): expect no hit, because widened sums must not wrap.
- Multiple hits with stalled reads: L=3, slots 5 and 2 overlap.
  - Expect hit_mask=8'h24, first_hit_idx=2, done at cycle 33.
  - obs_idx must hold stable during each stall.
- Inactive slot: slot 4 overlaps the player geometrically but obs_active=0. Expect hit_mask bit 4 = 0 and hit=0.
- Overrun and stability: frame_tick at cycle 5 of a scan.
  - Expect overrun=1 (sticky).
  - Expect the scan to finish unchanged and the previous results to hold until done.
- Reset mid-scan: rst_n low in REQ with slot=4.
  - Expect immediate obs_req=0, busy=0 and all results 0, with no done pulse.
  - After release, the next frame_tick starts a fresh scan at slot 0.
